// File: rtl/y_fetch_ctrl_pkg.sv
// Shared CPU package: fetch FSM encoding, default boot/handler addresses
// and the word-alignment helper applied to every loaded PC.
package y_fetch_ctrl_pkg;

  typedef enum logic {
    ST_BOOT = 1'b0,
    ST_RUN  = 1'b1
  } fetchState_t;

  localparam logic [31:0] DEFAULT_RESET_PC    = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_ENTRY_POINT = 32'h0000_0080;

  // Instruction fetches are word aligned; low two address bits are dropped.
  function automatic logic [31:0] alignPc(input logic [31:0] addr);
    return addr & ~32'h0000_0003;
  endfunction

endpackage

// File: rtl/y_fetch_ctrl_pc_next.sv
// Next-PC priority selector: interrupt > eret > redirect > stall > sequential.
// Purely combinational; also produces the flush/int_ack strobes and ISR bookkeeping.
module y_pc_next
  import y_fetch_ctrl_pkg::*;
#(
  parameter logic [31:0] ENTRY_POINT = DEFAULT_ENTRY_POINT
) (
  input  logic        run,
  input  logic        inIsr,
  input  logic        stall,
  input  logic        redirValid,
  input  logic        intReq,
  input  logic        eret,
  input  logic [31:0] pc,
  input  logic [31:0] pcP4,
  input  logic [31:0] epc,
  input  logic [31:0] redirTarget,
  output logic [31:0] nextPc,
  output logic [31:0] nextEpc,
  output logic        nextInIsr,
  output logic        flush,
  output logic        intAck
);

  logic takeInt;
  logic takeEret;

  // A stalled pipeline defers the interrupt; an open handler masks it.
  assign takeInt  = run & intReq & ~inIsr & ~stall;
  assign takeEret = run & eret & inIsr;

  always_comb begin
    nextPc    = pc;
    nextEpc   = epc;
    nextInIsr = inIsr;
    flush     = 1'b0;
    intAck    = 1'b0;
    if (takeInt) begin
      nextPc    = alignPc(ENTRY_POINT);
      nextEpc   = redirValid ? alignPc(redirTarget) : pcP4;
      nextInIsr = 1'b1;
      flush     = 1'b1;
      intAck    = 1'b1;
    end else if (takeEret) begin
      nextPc    = epc;
      nextInIsr = 1'b0;
      flush     = 1'b1;
    end else if (run && redirValid) begin
      nextPc = alignPc(redirTarget);
      flush  = 1'b1;
    end else if (run && !stall) begin
      nextPc = pcP4;
    end
  end

endmodule

// File: rtl/y_fetch_ctrl.sv
// Fetch controller: BOOT/RUN FSM plus PC, EPC and in-ISR registers.
// Next-PC selection lives in y_pc_next.
module y_fetch_ctrl
  import y_fetch_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = DEFAULT_RESET_PC,
  parameter logic [31:0] ENTRY_POINT = DEFAULT_ENTRY_POINT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redir_valid,
  input  logic [31:0] redir_target,
  input  logic        int_req,
  input  logic        eret,
  output logic [31:0] pc,
  output logic [31:0] pc_p4,
  output logic        fetch_valid,
  output logic        flush,
  output logic        int_ack,
  output logic [31:0] epc,
  output logic        in_isr,
  output fetchState_t dbgState
);

  // Handshake: redir_valid, int_req and eret have no ready; the controller
  // acts on them in the cycle they are presented (int_req is held by the
  // source until int_ack and is ignored while stalled or in_isr is high).

  fetchState_t state;
  logic [31:0] pcReg;
  logic [31:0] epcReg;
  logic        inIsrReg;
  logic [31:0] pcP4;
  logic [31:0] nextPc;
  logic [31:0] nextEpc;
  logic        nextInIsr;
  logic        run;

  assign pcP4 = pcReg + 32'd4;
  // Reset is synchronous, but outputs must already be quiet while it is held.
  assign run  = (state == ST_RUN) & ~rst;

  y_pc_next #(
    .ENTRY_POINT (ENTRY_POINT)
  ) u_pc_next (
    .run         (run),
    .inIsr       (inIsrReg),
    .stall       (stall),
    .redirValid  (redir_valid),
    .intReq      (int_req),
    .eret        (eret),
    .pc          (pcReg),
    .pcP4        (pcP4),
    .epc         (epcReg),
    .redirTarget (redir_target),
    .nextPc      (nextPc),
    .nextEpc     (nextEpc),
    .nextInIsr   (nextInIsr),
    .flush       (flush),
    .intAck      (int_ack)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_BOOT;
      pcReg    <= alignPc(RESET_PC);
      epcReg   <= 32'h0;
      inIsrReg <= 1'b0;
    end else begin
      case (state)
        ST_BOOT: state <= ST_RUN;
        ST_RUN:  state <= ST_RUN;
        default: state <= ST_BOOT;
      endcase
      pcReg    <= nextPc;
      epcReg   <= nextEpc;
      inIsrReg <= nextInIsr;
    end
  end

  assign pc          = pcReg;
  assign pc_p4       = pcP4;
  assign epc         = epcReg;
  assign in_isr      = inIsrReg;
  assign fetch_valid = run;
  assign dbgState    = state;

endmodule

// File: tb/tb_y_fetch_ctrl.sv
// Bench for y_fetch_ctrl: directed scenarios then random traffic, all checked
// against a cycle model built from the fetch/interrupt rules.
module tb_y_fetch_ctrl;
  import y_fetch_ctrl_pkg::*;

  localparam logic [31:0] RPC = 32'h0000_0000;
  localparam logic [31:0] EP  = 32'h0000_0080;

  // clock / reset block
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, stall, redir_valid, int_req, eret;
  logic [31:0] redir_target;
  logic [31:0] pc, pc_p4, epc;
  logic        fetch_valid, flush, int_ack, in_isr;
  fetchState_t dbg_state;

  y_fetch_ctrl #(.RESET_PC(RPC), .ENTRY_POINT(EP)) dut (
    .clk          (clk),
    .rst          (rst),
    .stall        (stall),
    .redir_valid  (redir_valid),
    .redir_target (redir_target),
    .int_req      (int_req),
    .eret         (eret),
    .pc           (pc),
    .pc_p4        (pc_p4),
    .fetch_valid  (fetch_valid),
    .flush        (flush),
    .int_ack      (int_ack),
    .epc          (epc),
    .in_isr       (in_isr),
    .dbgState     (dbg_state)
  );

  // scoreboard
  int          n_asserts = 0;
  int          n_fails   = 0;
  logic [31:0] exp_q[$];
  logic        fv_log[$];
  bit          trace_on  = 0;

  // reference model state
  logic        m_run;
  logic [31:0] m_pc, m_epc;
  logic        m_isr;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_asserts++;
    assert (obs === expv) else begin
      n_fails++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, expv);
    end
  endtask

  // driver: one cycle of inputs, check outputs mid-cycle, advance model
  task automatic step(input logic r, input logic s, input logic rv,
                      input logic [31:0] tgt, input logic ir, input logic er);
    logic        live, take_int, take_eret, exp_flush;
    logic [31:0] a_tgt;
    bit          ev[5];
    int          sel;
    rst = r; stall = s; redir_valid = rv; redir_target = tgt; int_req = ir; eret = er;
    a_tgt     = tgt & ~32'h3;
    live      = m_run && !r;
    take_int  = live && ir && !m_isr && !s;
    take_eret = live && er && m_isr;
    exp_flush = take_int || take_eret || (live && rv);
    @(negedge clk);
    check("pc", pc, m_pc);
    check("pc_p4", pc_p4, m_pc + 32'd4);
    check("fetch_valid", {31'b0, fetch_valid}, {31'b0, live});
    check("flush", {31'b0, flush}, {31'b0, exp_flush});
    check("int_ack", {31'b0, int_ack}, {31'b0, take_int});
    check("epc", epc, m_epc);
    check("in_isr", {31'b0, in_isr}, {31'b0, m_isr});
    check("dbg_state", {31'b0, dbg_state == ST_RUN}, {31'b0, m_run});
    if (trace_on) begin
      fv_log.push_back(fetch_valid);
      if (fetch_valid && exp_q.size() > 0) check("req40_fetch_pc", pc, exp_q.pop_front());
    end
    if (r) begin
      m_run = 0; m_pc = RPC; m_epc = 32'h0; m_isr = 0;
    end else if (!m_run) begin
      m_run = 1;
    end else begin
      ev  = '{take_int, take_eret, rv, s, 1'b1};
      sel = 4;
      for (int i = 4; i >= 0; i--) if (ev[i]) sel = i;
      case (sel)
        0: begin m_epc = rv ? a_tgt : m_pc + 32'd4; m_pc = EP; m_isr = 1; end
        1: begin m_pc = m_epc; m_isr = 0; end
        2: m_pc = a_tgt;
        3: m_pc = m_pc;
        default: m_pc = m_pc + 32'd4;
      endcase
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1; stall = 0; redir_valid = 0; redir_target = 32'h0; int_req = 0; eret = 0;
    repeat (2) @(posedge clk);
    #1;
    m_run = 0; m_pc = RPC; m_epc = 32'h0; m_isr = 0;

    // reset held with int_req raised
    step(1, 0, 0, 32'h0, 1, 0);
    step(1, 0, 1, 32'h200, 1, 1);

    // reset release, idle: valid fetches at 0x0, 0x4, 0x8
    exp_q = '{32'h0, 32'h4, 32'h8};
    trace_on = 1;
    for (int i = 0; i < 4; i++) step(0, 0, 0, 32'h0, 0, 0);
    trace_on = 0;
    check("req40_fv0", {31'b0, fv_log[0]}, 32'h0);
    check("req40_fv1", {31'b0, fv_log[1]}, 32'h1);
    check("req40_fv2", {31'b0, fv_log[2]}, 32'h1);
    check("req40_drained", exp_q.size(), 32'h0);

    // stall two cycles, redirect to 0x43 in the second
    step(0, 0, 1, 32'h10, 0, 0);
    check("req41_at10", pc, 32'h10);
    step(0, 1, 0, 32'h0, 0, 0);
    check("req41_hold", pc, 32'h10);
    step(0, 1, 1, 32'h43, 0, 0);
    check("req41_pc", pc, 32'h40);

    // interrupt together with a redirect
    step(0, 0, 1, 32'h20, 0, 0);
    step(0, 0, 1, 32'h100, 1, 0);
    check("req42_pc", pc, 32'h80);
    check("req42_epc", epc, 32'h100);
    check("req42_isr", {31'b0, in_isr}, 32'h1);

    // int_req held in ISR, then eret, then immediate re-entry
    step(0, 0, 0, 32'h0, 1, 0);
    step(0, 0, 0, 32'h0, 1, 0);
    step(0, 0, 0, 32'h0, 1, 1);
    check("req43_ret_pc", pc, 32'h100);
    check("req43_ret_isr", {31'b0, in_isr}, 32'h0);
    step(0, 0, 0, 32'h0, 1, 0);
    check("req43_reenter_pc", pc, 32'h80);
    check("req43_reenter_epc", epc, 32'h104);
    step(0, 0, 0, 32'h0, 0, 1);
    check("req43_exit_pc", pc, 32'h104);

    // wrap, then eret outside ISR
    step(0, 0, 1, 32'hFFFF_FFFF, 0, 0);
    check("req44_top", pc, 32'hFFFF_FFFC);
    step(0, 0, 0, 32'h0, 0, 0);
    check("req44_wrap", pc, 32'h0);
    step(0, 0, 0, 32'h0, 0, 1);
    check("req44_eret_ign", pc, 32'h4);

    // interrupt deferred by stall, then reset against a takeable interrupt
    step(0, 1, 0, 32'h0, 1, 0);
    check("defer_pc", pc, 32'h4);
    step(1, 0, 0, 32'h0, 1, 0);
    check("req45_pc", pc, RPC);
    check("req45_isr", {31'b0, in_isr}, 32'h0);
    check("req45_epc", epc, 32'h0);
    step(0, 0, 0, 32'h0, 1, 0);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 39) == 0, $urandom_range(0, 3) == 0,
           $urandom_range(0, 4) == 0,
           ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF0 | $urandom_range(0, 15) : $urandom,
           $urandom_range(0, 2) == 0, $urandom_range(0, 4) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
    $finish;
  end

endmodule
